// File: rtl/banco_reg_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// a post-reset clear sweep, an optional hardwired-zero entry 0 and optional write-to-read bypass.
module banco_reg_param #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter bit                ZERO_REG = 1'b1,
  parameter bit                BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RR1,
  input  logic [ADDR_W-1:0] RR2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] Writedata,
  input  logic              Regwrite,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              ready
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              ready_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wrEn;

  assign cnt_d = cnt_q + ADDR_W'(1);

  // Sweep control: the counter stops on the last entry so it simply holds while in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      if (cnt_q == LAST_IDX) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign wrEn = (state_q == RUN) && Regwrite && !(ZERO_REG && (WriteReg == '0));

  // Storage has no reset of its own; the sweep is the only way entries get cleared.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      regs_q[cnt_q] <= INIT_VAL;
    end else if (wrEn) begin
      regs_q[WriteReg] <= Writedata;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(
    input logic              isReady,
    input logic [ADDR_W-1:0] addr,
    input logic              writing,
    input logic [ADDR_W-1:0] wrAddr,
    input logic [DATA_W-1:0] wrData,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] value;
    value = '0;
    if (!isReady) begin
      value = '0;
    end else if (ZERO_REG && (addr == '0)) begin
      value = '0;
    end else if (BYPASS && writing && (wrAddr == addr)) begin
      value = wrData;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  always_comb begin
    RD1 = readPort(ready_q, RR1, wrEn, WriteReg, Writedata, regs_q[RR1]);
    RD2 = readPort(ready_q, RR2, wrEn, WriteReg, Writedata, regs_q[RR2]);
  end

  assign ready = ready_q;

endmodule
